// File: rtl/vector_mac_sequencer.sv
// rtl/vector_mac_sequencer.sv - Tile sequencer driving a K-step per-lane MAC accumulation
module vector_mac_sequencer #(
  parameter int REG_WIDTH = 16,
  parameter int VECTOR    = 8,
  parameter int ACC_WIDTH = 2*REG_WIDTH,
  parameter int K_WIDTH   = 8,
  parameter int MAC_LAT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [VECTOR*REG_WIDTH-1:0]   in_a,
  input  logic [VECTOR*REG_WIDTH-1:0]   in_b,
  input  logic [K_WIDTH-1:0]            k_len,
  output logic [VECTOR*REG_WIDTH-1:0]   mac_a,
  output logic [VECTOR*REG_WIDTH-1:0]   mac_b,
  output logic [VECTOR*ACC_WIDTH-1:0]   mac_c,
  input  logic [VECTOR*ACC_WIDTH-1:0]   mac_res,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VECTOR*ACC_WIDTH-1:0]   out_data,
  output logic                          busy
);

  localparam int LAT_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, FETCH, OUT} state_t;

  state_t               state;
  logic [K_WIDTH-1:0]   step_cnt;
  logic [K_WIDTH-1:0]   k_reg;
  logic [LAT_W-1:0]     lat_cnt;

  // mac_a/mac_b double as the operand registers and mac_c as the accumulator:
  // mac_c is zeroed on the first step of a tile and loaded with mac_res after every step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_c     <= '0;
      out_data  <= '0;
      step_cnt  <= '0;
      k_reg     <= '0;
      lat_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mac_a    <= in_a;
            mac_b    <= in_b;
            mac_c    <= '0;
            k_reg    <= (k_len == '0) ? K_WIDTH'(1) : k_len;
            step_cnt <= '0;
            lat_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_cnt == LAT_W'(MAC_LAT)) begin
            mac_c    <= mac_res;
            step_cnt <= step_cnt + K_WIDTH'(1);
            if (step_cnt == k_reg - K_WIDTH'(1)) begin
              out_data  <= mac_res;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              in_ready <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (in_valid) begin
            mac_a    <= in_a;
            mac_b    <= in_b;
            lat_cnt  <= '0;
            in_ready <= 1'b0;
            state    <= EXEC;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mac_sequencer.sv
// tb/tb_vector_mac_sequencer.sv - Scoreboard bench for vector_mac_sequencer at MAC_LAT 0 and 2
module tb_vector_mac_sequencer;

  localparam int RW = 16;
  localparam int V  = 8;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int AV = V*RW;
  localparam int CV = V*AW;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CV-1:0] act, input logic [CV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mul(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [AW-1:0] x, y;
    x = AW'(a);
    y = AW'(b);
    return x * y;
  endfunction

  function automatic logic [AV-1:0] splat(input logic [RW-1:0] x);
    return {V{x}};
  endfunction

  function automatic logic [CV-1:0] wsplat(input logic [AW-1:0] x);
    return {V{x}};
  endfunction

  function automatic logic [AV-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : blk
    localparam int LAT = 2*g;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, busy;
    logic [AV-1:0] in_a = '0;
    logic [AV-1:0] in_b = '0;
    logic [KW-1:0] k_len = '0;
    logic [AV-1:0] mac_a, mac_b;
    logic [CV-1:0] mac_c, mac_res, mac_f, out_data;
    logic          done = 1'b0;
    logic [CV-1:0] exp_q[$];
    logic [AV-1:0] sa[$];
    logic [AV-1:0] sb[$];

    vector_mac_sequencer #(
      .REG_WIDTH(RW), .VECTOR(V), .ACC_WIDTH(AW), .K_WIDTH(KW), .MAC_LAT(LAT)
    ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .k_len(k_len),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_res(mac_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // Behavioural MAC: out = a*b + c per lane, optionally behind LAT register stages.
    always_comb begin
      mac_f = '0;
      for (int j = 0; j < V; j++)
        mac_f[j*AW +: AW] = mul(mac_a[j*RW +: RW], mac_b[j*RW +: RW]) + mac_c[j*AW +: AW];
    end

    if (LAT == 0) begin : comb_mac
      assign mac_res = mac_f;
    end else begin : reg_mac
      logic [CV-1:0] p1, p2;
      always @(posedge clk) begin
        p1 <= mac_f;
        p2 <= p1;
      end
      assign mac_res = p2;
    end

    always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL L%0d_unexpected_result actual=%h required=none", LAT, out_data);
        end else begin
          chk($sformatf("L%0d_result", LAT), out_data, exp_q.pop_front());
        end
      end
    end

    // Dot-product reference over the first n staged steps.
    function automatic logic [CV-1:0] ref_sum(input int n);
      logic [CV-1:0] r;
      r = '0;
      for (int s = 0; s < n; s++)
        for (int j = 0; j < V; j++)
          r[j*AW +: AW] = r[j*AW +: AW] + mul(sa[s][j*RW +: RW], sb[s][j*RW +: RW]);
      return r;
    endfunction

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
    endtask

    task automatic feed(input int kl, input int nfeed, input int gap_at, input int gap_len);
      for (int s = 0; s < nfeed; s++) begin
        int n;
        n = 0;
        if (s == gap_at) begin
          in_valid = 1'b0;
          for (int c = 0; c < gap_len; c++) tick();
          if (gap_len >= LAT + 1) begin
            chk($sformatf("L%0d_fetch_ready", LAT), in_ready, 1);
            chk($sformatf("L%0d_fetch_busy", LAT), busy, 1);
            chk($sformatf("L%0d_fetch_acc", LAT), mac_c, ref_sum(s));
          end
        end
        in_valid = 1'b1;
        in_a = sa[s];
        in_b = sb[s];
        k_len = (s == 0) ? KW'(kl) : KW'($urandom);
        while (!in_ready && n < 100) begin
          tick();
          n++;
        end
        if (n >= 100) chk($sformatf("L%0d_in_ready_timeout", LAT), 0, 1);
        tick();
        chk($sformatf("L%0d_exec_a_s%0d", LAT, s), mac_a, sa[s]);
        chk($sformatf("L%0d_exec_b_s%0d", LAT, s), mac_b, sb[s]);
        chk($sformatf("L%0d_exec_c_s%0d", LAT, s), mac_c, ref_sum(s));
      end
      in_valid = 1'b0;
    endtask

    task automatic drain(input int stall, input logic [CV-1:0] exp, output int lat_seen);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
        chk($sformatf("L%0d_exec_not_ready", LAT), in_ready, 0);
        tick();
        n++;
      end
      lat_seen = n;
      if (n >= 100) chk($sformatf("L%0d_out_valid_timeout", LAT), 0, 1);
      for (int c = 0; c < stall; c++) begin
        chk($sformatf("L%0d_stall_valid", LAT), out_valid, 1);
        chk($sformatf("L%0d_stall_data", LAT), out_data, exp);
        chk($sformatf("L%0d_stall_not_ready", LAT), in_ready, 0);
        in_valid = 1'($urandom);
        in_a = rnd_vec();
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("L%0d_post_valid", LAT), out_valid, 0);
      chk($sformatf("L%0d_post_busy", LAT), busy, 0);
      chk($sformatf("L%0d_post_ready", LAT), in_ready, 1);
    endtask

    task automatic stage_uniform(input logic [RW-1:0] a, input logic [RW-1:0] b);
      sa.push_back(splat(a));
      sb.push_back(splat(b));
    endtask

    initial begin
      int lat;
      int n;
      do_reset();
      chk($sformatf("L%0d_rst_in_ready", LAT), in_ready, 1);
      chk($sformatf("L%0d_rst_out_valid", LAT), out_valid, 0);
      chk($sformatf("L%0d_rst_busy", LAT), busy, 0);
      chk($sformatf("L%0d_rst_mac_a", LAT), mac_a, 0);
      chk($sformatf("L%0d_rst_mac_b", LAT), mac_b, 0);
      chk($sformatf("L%0d_rst_mac_c", LAT), mac_c, 0);
      chk($sformatf("L%0d_rst_out_data", LAT), out_data, 0);

      sa.delete(); sb.delete();
      stage_uniform(16'd3, 16'd4);
      exp_q.push_back(wsplat(32'd12));
      feed(1, 1, -1, 0);
      drain(0, wsplat(32'd12), lat);
      chk($sformatf("L%0d_single_latency", LAT), lat, LAT + 1);

      sa.delete(); sb.delete();
      stage_uniform(16'd1, 16'd2); stage_uniform(16'd3, 16'd4); stage_uniform(16'd5, 16'd6);
      exp_q.push_back(wsplat(32'd44));
      feed(3, 3, -1, 0);
      drain(0, wsplat(32'd44), lat);

      exp_q.push_back(wsplat(32'd44));
      feed(3, 3, 2, 4);
      drain(0, wsplat(32'd44), lat);

      sa.delete(); sb.delete();
      stage_uniform(16'd3, 16'd4);
      exp_q.push_back(wsplat(32'd12));
      feed(1, 1, -1, 0);
      drain(5, wsplat(32'd12), lat);

      sa.delete(); sb.delete();
      stage_uniform(16'd7, 16'd7);
      exp_q.push_back(wsplat(32'd49));
      feed(0, 1, -1, 0);
      drain(0, wsplat(32'd49), lat);

      sa.delete(); sb.delete();
      stage_uniform(16'hFFFF, 16'hFFFF); stage_uniform(16'hFFFF, 16'hFFFF);
      exp_q.push_back(wsplat(32'hFFFC0002));
      feed(2, 2, -1, 0);
      drain(1, wsplat(32'hFFFC0002), lat);

      sa.delete(); sb.delete();
      stage_uniform(16'd9, 16'd9); stage_uniform(16'd8, 16'd8); stage_uniform(16'd5, 16'd5);
      feed(3, 2, -1, 0);
      n = 0;
      while (!in_ready && n < 100) begin
        tick();
        n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk($sformatf("L%0d_midrst_in_ready", LAT), in_ready, 1);
      chk($sformatf("L%0d_midrst_out_valid", LAT), out_valid, 0);
      chk($sformatf("L%0d_midrst_busy", LAT), busy, 0);
      sa.delete(); sb.delete();
      stage_uniform(16'd2, 16'd2);
      exp_q.push_back(wsplat(32'd4));
      feed(1, 1, -1, 0);
      drain(0, wsplat(32'd4), lat);

      for (int t = 0; t < 12; t++) begin
        int kl, keff, gap_at, gap_len;
        logic [CV-1:0] e;
        kl = $urandom_range(0, 5);
        keff = (kl == 0) ? 1 : kl;
        sa.delete(); sb.delete();
        for (int s = 0; s < keff; s++) begin
          sa.push_back(rnd_vec());
          sb.push_back(rnd_vec());
        end
        gap_at = (keff > 1) ? $urandom_range(1, keff - 1) : -1;
        gap_len = $urandom_range(0, 4);
        e = ref_sum(keff);
        exp_q.push_back(e);
        feed(kl, keff, gap_at, gap_len);
        drain($urandom_range(0, 3), e, lat);
      end

      chk($sformatf("L%0d_scoreboard_empty", LAT), exp_q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int n;
    n = 0;
    while (!(blk[0].done && blk[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      errors++;
      $display("FAIL global_timeout actual=%0d required=done", n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
